key_repeat_filter: RTL and testbench

- Front-end key conditioner for the digital-clock design.
- Sits directly upstream of the time-setting logic and drives its key_vld input.
- Takes the raw, bouncy, active-low push-buttons and produces clean single-cycle press pulses.
- Holding a key for a long press produces auto-repeat pulses, so a held key can fast-step hours and minutes. A debounced level output is also provided for the alarm-silence logic.

---
 rtl/key_repeat_filter_if.sv | 12 +
 rtl/key_repeat_filter.sv | 142 ++++++++++++++
 tb/tb_key_repeat_filter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/key_repeat_filter_if.sv
// Key conditioner bundle: raw active-low keys in, press/repeat pulses and
// debounced hold levels out.
interface key_repeat_filter_if #(
  parameter int KEY_W = 3
);
  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] key_vld;
  logic [KEY_W-1:0] key_hold;

  modport master (output key_in, input key_vld, input key_hold);
  modport slave  (input key_in, output key_vld, output key_hold);
endinterface

// File: rtl/key_repeat_filter.sv
// Per-key synchronizer, debounce and auto-repeat FSM; emits one-clk press
// pulses (initial press plus repeats) and a debounced hold level.
module key_repeat_filter #(
  parameter int KEY_W        = 3,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000,
  parameter int CNT_W        = 25
) (
  input  logic                clk,
  input  logic                rst,
  key_repeat_filter_if.slave  kif
);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    REPEAT,
    DEB_REL
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [KEY_W-1:0] r_sync1;
  logic [KEY_W-1:0] r_sync2;
  logic [KEY_W-1:0] r_vld;
  logic [KEY_W-1:0] r_hold;
  state_t           r_state     [KEY_W];
  logic [CNT_W-1:0] r_cnt       [KEY_W];

  state_t           w_state_nxt [KEY_W];
  logic [CNT_W-1:0] w_cnt_nxt   [KEY_W];
  logic [KEY_W-1:0] w_vld_nxt;
  logic [KEY_W-1:0] w_hold_nxt;

  // Synchronizers reset to released so no press is seen coming out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= kif.key_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < KEY_W; k++) begin
        r_state[k] <= IDLE;
        r_cnt[k]   <= '0;
      end
      r_vld  <= '0;
      r_hold <= '0;
    end else begin
      for (int unsigned k = 0; k < KEY_W; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_cnt[k]   <= w_cnt_nxt[k];
      end
      r_vld  <= w_vld_nxt;
      r_hold <= w_hold_nxt;
    end
  end

  always_comb begin
    w_vld_nxt  = '0;
    w_hold_nxt = '0;
    for (int unsigned k = 0; k < KEY_W; k++) begin
      w_state_nxt[k] = r_state[k];
      w_cnt_nxt[k]   = r_cnt[k];
      unique case (r_state[k])
        IDLE: begin
          if (!r_sync2[k]) begin
            w_state_nxt[k] = DEB_PRESS;
            w_cnt_nxt[k]   = '0;
          end
        end
        DEB_PRESS: begin
          if (r_sync2[k]) begin
            w_state_nxt[k] = IDLE;
            w_cnt_nxt[k]   = '0;
          end else if (r_cnt[k] == DEB_LAST) begin
            w_state_nxt[k] = PRESSED;
            w_cnt_nxt[k]   = '0;
            w_vld_nxt[k]   = 1'b1;
          end else begin
            w_cnt_nxt[k] = r_cnt[k] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (r_sync2[k]) begin
            w_state_nxt[k] = DEB_REL;
            w_cnt_nxt[k]   = '0;
          end else if (r_cnt[k] == LONG_LAST) begin
            w_state_nxt[k] = REPEAT;
            w_cnt_nxt[k]   = '0;
            w_vld_nxt[k]   = 1'b1;
          end else begin
            w_cnt_nxt[k] = r_cnt[k] + CNT_ONE;
          end
        end
        REPEAT: begin
          if (r_sync2[k]) begin
            w_state_nxt[k] = DEB_REL;
            w_cnt_nxt[k]   = '0;
          end else if (r_cnt[k] == REP_LAST) begin
            w_cnt_nxt[k] = '0;
            w_vld_nxt[k] = 1'b1;
          end else begin
            w_cnt_nxt[k] = r_cnt[k] + CNT_ONE;
          end
        end
        DEB_REL: begin
          // A low sample here is a release bounce: re-arm long-press timing.
          if (!r_sync2[k]) begin
            w_state_nxt[k] = PRESSED;
            w_cnt_nxt[k]   = '0;
          end else if (r_cnt[k] == DEB_LAST) begin
            w_state_nxt[k] = IDLE;
            w_cnt_nxt[k]   = '0;
          end else begin
            w_cnt_nxt[k] = r_cnt[k] + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt[k] = IDLE;
          w_cnt_nxt[k]   = '0;
        end
      endcase
      w_hold_nxt[k] = (w_state_nxt[k] == PRESSED) || (w_state_nxt[k] == REPEAT) ||
                      (w_state_nxt[k] == DEB_REL);
    end
  end

  assign kif.key_vld  = r_vld;
  assign kif.key_hold = r_hold;

endmodule

// File: tb/tb_key_repeat_filter.sv
// Directed bench for key_repeat_filter with short debounce/long/repeat counts.
module tb_key_repeat_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   pq [3][$];
  int   exp_q [$];
  int   c;
  logic acc;

  key_repeat_filter_if #(.KEY_W(3)) kif ();

  key_repeat_filter #(
    .KEY_W(3),
    .DEBOUNCE_CYC(4),
    .LONG_CYC(20),
    .REPEAT_CYC(5),
    .CNT_W(25)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kif(kif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (kif.key_vld[k]) pq[k].push_back(cyc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    for (int k = 0; k < 3; k++) pq[k].delete();
  endtask

  task automatic check_q(input string tag, input int k);
    check({tag, "_cnt"}, pq[k].size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_at"}, (i < pq[k].size()) ? pq[k][i] : -1, exp_q[i]);
  endtask

  initial begin
    kif.key_in = '0;
    nxt(3);
    check("rst_vld", kif.key_vld, 3'b000);
    check("rst_hold", kif.key_hold, 3'b000);

    // reset exit with keys already low
    clr();
    c = cyc;
    rst = 1'b0;
    nxt(6);
    check("rx_hold_pre", kif.key_hold, 3'b000);
    check("rx_vld_pre", kif.key_vld, 3'b000);
    nxt(1);
    check("rx_hold", kif.key_hold, 3'b111);
    check("rx_vld", kif.key_vld, 3'b111);
    nxt(1);
    check("rx_vld_post", kif.key_vld, 3'b000);
    nxt(4);
    exp_q = '{c + 7};
    for (int k = 0; k < 3; k++) check_q("rx_q", k);
    kif.key_in = '1;
    nxt(12);
    check("rx_hold_rel", kif.key_hold, 3'b000);

    // clean press of key 0
    clr();
    c = cyc;
    kif.key_in[0] = 1'b0;
    nxt(10);
    kif.key_in[0] = 1'b1;
    nxt(6);
    check("cp_hold_on", kif.key_hold[0], 1'b1);
    nxt(1);
    check("cp_hold_off", kif.key_hold[0], 1'b0);
    nxt(5);
    exp_q = '{c + 7};
    check_q("cp_q0", 0);
    exp_q = '{};
    check_q("cp_q1", 1);
    check_q("cp_q2", 2);

    // bouncing key 1
    clr();
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      kif.key_in[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        nxt(1);
        acc = acc | kif.key_hold[1];
      end
    end
    kif.key_in[1] = 1'b1;
    repeat (10) begin
      nxt(1);
      acc = acc | kif.key_hold[1];
    end
    exp_q = '{};
    check_q("bn_q1", 1);
    check("bn_hold", acc, 1'b0);

    // long hold of key 2
    clr();
    c = cyc;
    kif.key_in[2] = 1'b0;
    nxt(60);
    kif.key_in[2] = 1'b1;
    nxt(6);
    check("lh_hold_on", kif.key_hold[2], 1'b1);
    nxt(1);
    check("lh_hold_off", kif.key_hold[2], 1'b0);
    nxt(13);
    exp_q = '{c + 7, c + 27, c + 32, c + 37, c + 42, c + 47, c + 52, c + 57, c + 62};
    check_q("lh_q2", 2);

    // release bounce on key 0
    clr();
    c = cyc;
    kif.key_in[0] = 1'b0;
    nxt(7);
    check("rb_hold_on", kif.key_hold[0], 1'b1);
    acc = 1'b1;
    repeat (3) begin
      nxt(1);
      acc = acc & kif.key_hold[0];
    end
    kif.key_in[0] = 1'b1;
    repeat (2) begin
      nxt(1);
      acc = acc & kif.key_hold[0];
    end
    kif.key_in[0] = 1'b0;
    repeat (24) begin
      nxt(1);
      acc = acc & kif.key_hold[0];
    end
    kif.key_in[0] = 1'b1;
    check("rb_hold_kept", acc, 1'b1);
    nxt(14);
    check("rb_hold_off", kif.key_hold[0], 1'b0);
    exp_q = '{c + 7, c + 35};
    check_q("rb_q0", 0);

    // keys 0 and 1 together, then reset mid-hold
    clr();
    c = cyc;
    kif.key_in = 3'b100;
    nxt(7);
    check("sm_vld", kif.key_vld, 3'b011);
    check("sm_hold", kif.key_hold, 3'b011);
    nxt(3);
    check("sm_hold_pre_rst", kif.key_hold, 3'b011);
    clr();
    rst = 1'b1;
    #1;
    check("sm_rst_vld", kif.key_vld, 3'b000);
    check("sm_rst_hold", kif.key_hold, 3'b000);
    nxt(2);
    rst = 1'b0;
    nxt(3);
    check("sm_no_pulse", pq[0].size() + pq[1].size() + pq[2].size(), 0);
    nxt(4);
    check("sm_requal_vld", kif.key_vld, 3'b011);
    kif.key_in = '1;
    nxt(12);
    check("sm_final_hold", kif.key_hold, 3'b000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
